// File: rtl/uart_boot_sequencer_if.sv
// Signal bundle between the board-side controls / UART status and the boot sequencer.
// The sequencer takes the slave view; whatever drives the buttons and UART status takes the master view.
interface uart_boot_sequencer_if;
  logic       start_load;
  logic       start_dump;
  logic       IM_Done;
  logic       DM_Done;
  logic       cpu_reset;
  logic       uart_on;
  logic       uart_mode;
  logic       uart_ram_id;
  logic       busy;
  logic       error;
  logic [2:0] state;

  modport master (
    output start_load, start_dump, IM_Done, DM_Done,
    input  cpu_reset, uart_on, uart_mode, uart_ram_id, busy, error, state
  );

  modport slave (
    input  start_load, start_dump, IM_Done, DM_Done,
    output cpu_reset, uart_on, uart_mode, uart_ram_id, busy, error, state
  );
endinterface

// File: rtl/uart_boot_sequencer.sv
// Boot sequencer: holds the CPU in reset while IM then DM are loaded over UART,
// releases it after a fixed delay, and halts it again to dump DM on request.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | core held in reset, UART off, waiting for a load request
// LOAD_IM | UART receiving into instruction memory
// LOAD_DM | UART receiving into data memory
// RELEASE | UART off, core still in reset for RELEASE_CYCLES cycles
// RUN     | core running
// DUMP_DM | core halted, UART transmitting data memory
// ERROR   | a UART phase timed out; only a new load request recovers
module uart_boot_sequencer #(
  parameter int unsigned RELEASE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES = 100000000,
  parameter int unsigned CNT_W          = 32
) (
  input logic                  clk,
  input logic                  reset,
  uart_boot_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_IM = 3'd1,
    LOAD_DM = 3'd2,
    RELEASE = 3'd3,
    RUN     = 3'd4,
    DUMP_DM = 3'd5,
    ERROR   = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] REL_LAST =
    (RELEASE_CYCLES == 0) ? '0 : CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t           state_q;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             timed_out;
  logic             counting;

  // in_q is the registered input, in_qq the value one cycle older; bit order {DM, IM, dump, load}
  logic [3:0] in_q;
  logic [3:0] in_qq;
  logic [3:0] ev;
  logic       ev_load;
  logic       ev_dump;
  logic       ev_im;
  logic       ev_dm;

  logic cpu_reset_q;
  logic uart_on_q;
  logic uart_mode_q;
  logic uart_ram_id_q;
  logic busy_q;
  logic error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q  <= '0;
      in_qq <= '0;
    end else begin
      in_q  <= {bus.DM_Done, bus.IM_Done, bus.start_dump, bus.start_load};
      in_qq <= in_q;
    end
  end

  assign ev      = in_q & ~in_qq;
  assign ev_load = ev[0];
  assign ev_dump = ev[1];
  assign ev_im   = ev[2];
  assign ev_dm   = ev[3];

  assign timed_out = TO_EN && (cnt >= TO_LAST);

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (ev_load) state_next = LOAD_IM;
      end
      LOAD_IM: begin
        if (ev_im)          state_next = LOAD_DM;
        else if (timed_out) state_next = ERROR;
      end
      LOAD_DM: begin
        if (ev_dm)          state_next = RELEASE;
        else if (timed_out) state_next = ERROR;
      end
      RELEASE: begin
        if (cnt >= REL_LAST) state_next = RUN;
      end
      RUN: begin
        // a load request outranks a dump request in the same cycle
        if (ev_load)      state_next = LOAD_IM;
        else if (ev_dump) state_next = DUMP_DM;
      end
      DUMP_DM: begin
        if (ev_dm)          state_next = IDLE;
        else if (timed_out) state_next = ERROR;
      end
      ERROR: begin
        if (ev_load) state_next = LOAD_IM;
      end
      default: state_next = IDLE;
    endcase
  end

  assign counting = (state_q == LOAD_IM) || (state_q == LOAD_DM) ||
                    (state_q == DUMP_DM) || (state_q == RELEASE);

  // Shared release/timeout counter: restarts on every state change and saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_next != state_q) begin
      cnt <= '0;
    end else if (counting) begin
      if (cnt != '1) cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  // Outputs are decoded from the next state so they change on the edge that enters a state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cpu_reset_q   <= 1'b1;
      uart_on_q     <= 1'b0;
      uart_mode_q   <= 1'b0;
      uart_ram_id_q <= 1'b0;
      busy_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_next;
      cpu_reset_q   <= (state_next != RUN);
      uart_on_q     <= (state_next == LOAD_IM) || (state_next == LOAD_DM) ||
                       (state_next == DUMP_DM);
      uart_mode_q   <= (state_next == DUMP_DM);
      uart_ram_id_q <= (state_next == LOAD_DM) || (state_next == DUMP_DM);
      busy_q        <= (state_next == LOAD_IM) || (state_next == LOAD_DM) ||
                       (state_next == DUMP_DM) || (state_next == RELEASE);
      error_q       <= (state_next == ERROR);
    end
  end

  assign bus.state       = state_q;
  assign bus.cpu_reset   = cpu_reset_q;
  assign bus.uart_on     = uart_on_q;
  assign bus.uart_mode   = uart_mode_q;
  assign bus.uart_ram_id = uart_ram_id_q;
  assign bus.busy        = busy_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_uart_boot_sequencer.sv
// Bench for uart_boot_sequencer: two instances (long and short timeout) driven by the same
// inputs, compared every cycle against a behavioural model plus directed scenario checks.
module tb_uart_boot_sequencer;

  localparam int REL = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_load = 1'b0;
  logic start_dump = 1'b0;
  logic im_done = 1'b0;
  logic dm_done = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_boot_sequencer_if bus0();
  uart_boot_sequencer_if bus1();

  assign bus0.start_load = start_load;
  assign bus0.start_dump = start_dump;
  assign bus0.IM_Done    = im_done;
  assign bus0.DM_Done    = dm_done;
  assign bus1.start_load = start_load;
  assign bus1.start_dump = start_dump;
  assign bus1.IM_Done    = im_done;
  assign bus1.DM_Done    = dm_done;

  uart_boot_sequencer #(.RELEASE_CYCLES(REL)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));

  uart_boot_sequencer #(.RELEASE_CYCLES(REL), .TIMEOUT_CYCLES(8), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. States: 0 idle, 1 load IM, 2 load DM, 3 release, 4 run, 5 dump, 6 error.
  // An input rise sampled on edge k is acted on at edge k+1.
  int       m_st[2];
  int       m_dw[2];   // full cycles already spent in the current state
  int       tol[2] = '{100000000, 8};
  bit [3:0] h1, h2;    // inputs sampled on the previous edge and the one before

  function automatic int next_st(input int s, input int dw, input bit [3:0] ev, input int lim);
    bit l, d, im, dm, to;
    l  = ev[0];
    d  = ev[1];
    im = ev[2];
    dm = ev[3];
    to = (lim != 0) && (dw >= lim - 1);
    case (s)
      0: return l ? 1 : 0;
      1: return im ? 2 : (to ? 6 : 1);
      2: return dm ? 3 : (to ? 6 : 2);
      3: return (dw >= REL - 1) ? 4 : 3;
      4: return l ? 1 : (d ? 5 : 4);
      5: return dm ? 0 : (to ? 6 : 5);
      6: return l ? 1 : 6;
      default: return 0;
    endcase
  endfunction

  // {cpu_reset, uart_on, uart_mode, uart_ram_id, busy, error}
  function automatic int exp_outs(input int s);
    bit [5:0] o;
    o[5] = (s != 4);
    o[4] = (s == 1) || (s == 2) || (s == 5);
    o[3] = (s == 5);
    o[2] = (s == 2) || (s == 5);
    o[1] = (s == 1) || (s == 2) || (s == 3) || (s == 5);
    o[0] = (s == 6);
    return int'(o);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0;
      m_dw[i] = 0;
    end
    h1 = '0;
    h2 = '0;
  endtask

  task automatic model_step();
    bit [3:0] ev;
    int ns;
    ev = h1 & ~h2;
    for (int i = 0; i < 2; i++) begin
      ns = next_st(m_st[i], m_dw[i], ev, tol[i]);
      m_dw[i] = (ns != m_st[i]) ? 0 : m_dw[i] + 1;
      m_st[i] = ns;
    end
    h2 = h1;
    h1 = {dm_done, im_done, start_dump, start_load};
  endtask

  task automatic compare();
    chk("st0", int'(bus0.state), m_st[0]);
    chk("out0", int'({bus0.cpu_reset, bus0.uart_on, bus0.uart_mode, bus0.uart_ram_id,
                      bus0.busy, bus0.error}), exp_outs(m_st[0]));
    chk("st1", int'(bus1.state), m_st[1]);
    chk("out1", int'({bus1.cpu_reset, bus1.uart_on, bus1.uart_mode, bus1.uart_ram_id,
                      bus1.busy, bus1.error}), exp_outs(m_st[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    compare();
  endtask

  task automatic wait_run0(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (bus0.state == 3'd4) break;
      tick();
    end
    chk("wait_run", int'(bus0.state), 4);
  endtask

  // Counts entries of dut0 into LOAD_IM while the level-hold scenario runs.
  bit t6_on = 1'b0;
  int t6_entries = 0;
  int t6_prev = 0;
  always @(negedge clk) begin
    if (t6_on && bus0.state == 3'd1 && t6_prev != 1) t6_entries++;
    t6_prev = int'(bus0.state);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    // T1: reset then idle, dump request ignored
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("t1_state", int'(bus0.state), 0);
    chk("t1_cpu_reset", int'(bus0.cpu_reset), 1);
    chk("t1_uart_on", int'(bus0.uart_on), 0);
    start_dump = 1'b1;
    tick();
    start_dump = 1'b0;
    repeat (3) tick();
    chk("t1_dump_ignored", int'(bus0.state), 0);

    // T2: full boot with long gaps
    repeat (6) tick();
    start_load = 1'b1;
    tick();
    chk("t2_latency", int'(bus0.state), 0);
    tick();
    chk("t2_load_im", int'(bus0.state), 1);
    start_load = 1'b0;
    repeat (38) tick();
    im_done = 1'b1;
    tick();
    tick();
    chk("t2_load_dm", int'(bus0.state), 2);
    im_done = 1'b0;
    repeat (38) tick();
    dm_done = 1'b1;
    tick();
    tick();
    chk("t2_release", int'(bus0.state), 3);
    dm_done = 1'b0;
    for (int k = 0; k < REL - 1; k++) begin
      tick();
      chk("t2_hold_reset", int'(bus0.cpu_reset), 1);
    end
    tick();
    chk("t2_run_cpu_reset", int'(bus0.cpu_reset), 0);
    chk("t2_run_state", int'(bus0.state), 4);

    // T3: dump from RUN
    start_dump = 1'b1;
    tick();
    tick();
    chk("t3_state", int'(bus0.state), 5);
    chk("t3_mode", int'(bus0.uart_mode), 1);
    chk("t3_ram_id", int'(bus0.uart_ram_id), 1);
    chk("t3_cpu_reset", int'(bus0.cpu_reset), 1);
    start_dump = 1'b0;
    repeat (5) tick();
    dm_done = 1'b1;
    tick();
    tick();
    chk("t3_idle", int'(bus0.state), 0);
    dm_done = 1'b0;
    tick();

    // T4: timeout on the short-timeout instance
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    start_load = 1'b1;
    tick();
    tick();
    chk("t4_enter", int'(bus1.state), 1);
    repeat (7) tick();
    chk("t4_before_timeout", int'(bus1.state), 1);
    tick();
    chk("t4_error_state", int'(bus1.state), 6);
    chk("t4_error_flag", int'(bus1.error), 1);
    chk("t4_uart_off", int'(bus1.uart_on), 0);
    start_load = 1'b0;
    tick();
    start_load = 1'b1;
    tick();
    tick();
    chk("t4_recover_state", int'(bus1.state), 1);
    chk("t4_recover_error", int'(bus1.error), 0);
    start_load = 1'b0;
    tick();

    // T5: simultaneous load/dump in RUN, then abort by reset in LOAD_DM
    im_done = 1'b1;
    tick();
    im_done = 1'b0;
    tick();
    dm_done = 1'b1;
    tick();
    dm_done = 1'b0;
    wait_run0(40);
    start_load = 1'b1;
    start_dump = 1'b1;
    tick();
    tick();
    chk("t5_load_wins", int'(bus0.state), 1);
    start_load = 1'b0;
    start_dump = 1'b0;
    im_done = 1'b1;
    tick();
    tick();
    chk("t5_in_load_dm", int'(bus0.state), 2);
    im_done = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("t5_abort_state", int'(bus0.state), 0);
    chk("t5_abort_outs", int'({bus0.cpu_reset, bus0.uart_on, bus0.uart_mode, bus0.uart_ram_id,
                               bus0.busy, bus0.error}), 6'b100000);
    tick();
    reset = 1'b0;
    tick();

    // T6: start_load held high through the whole boot; stale IM_Done in LOAD_DM
    t6_on = 1'b1;
    start_load = 1'b1;
    tick();
    tick();
    chk("t6_load_im", int'(bus0.state), 1);
    im_done = 1'b1;
    tick();
    tick();
    chk("t6_load_dm", int'(bus0.state), 2);
    im_done = 1'b0;
    tick();
    im_done = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_stale_im_done", int'(bus0.state), 2);
    im_done = 1'b0;
    dm_done = 1'b1;
    tick();
    dm_done = 1'b0;
    wait_run0(40);
    repeat (5) tick();
    t6_on = 1'b0;
    chk("t6_single_entry", t6_entries, 1);
    start_load = 1'b0;
    tick();

    // Randomized traffic checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) start_load = ~start_load;
      if ($urandom_range(0, 7) == 0) start_dump = ~start_dump;
      if ($urandom_range(0, 4) == 0) im_done = ~im_done;
      if ($urandom_range(0, 4) == 0) dm_done = ~dm_done;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
